// File: rtl/ifetch_queue.sv
// Instruction prefetch queue: owns the PC, fetches over req/ack and buffers {pc, inst} for decode.
// Optional IFQ_BYPASS_EN: an empty-queue fetch result is presented to decode in its completion cycle.
module ifetch_queue #(
   parameter int          DEPTH    = 4,
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ack,
   input  logic [31:0] imem_rdata,
   input  logic        redirect,
   input  logic [31:0] redirect_pc,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_inst,
   output logic [31:0] out_pc
);
   // state  | meaning
   // S_IDLE | no request outstanding
   // S_WAIT | request outstanding, result goes to the queue
   // S_DROP | request outstanding, result discarded after a redirect

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam logic [31:0] PC_MASK = 32'hFFFF_FFFC;

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DROP} state_t;

   state_t          r_state;
   state_t          w_state_next;
   logic [31:0]     r_fetch_pc;
   logic [31:0]     r_addr;
   logic [31:0]     r_mem_inst [DEPTH];
   logic [31:0]     r_mem_pc   [DEPTH];
   logic [AW-1:0]   r_wptr;
   logic [AW-1:0]   r_rptr;
   logic [CW-1:0]   r_cnt;

   logic [31:0]     w_redirect_pc;
   logic            w_complete;
   logic            w_fill;
   logic            w_fifo_empty;
   logic            w_bypass;
   logic            w_out_valid;
   logic            w_take;
   logic            w_push;
   logic            w_pop;
   logic [CW-1:0]   w_cnt_next;
   logic            w_has_room;
   logic            w_issue_idle;
   logic            w_issue_next;

   assign w_redirect_pc = redirect_pc & PC_MASK;
   assign w_complete    = (r_state != S_IDLE) && imem_ack;
   assign w_fill        = (r_state == S_WAIT) && w_complete && !redirect;
   assign w_fifo_empty  = (r_cnt == '0);

`ifdef IFQ_BYPASS_EN
   assign w_bypass = w_fill && w_fifo_empty;
`else
   assign w_bypass = 1'b0;
`endif

   assign w_out_valid = !w_fifo_empty || w_bypass;
   assign w_take      = w_out_valid && out_ready && !redirect;
   // A bypassed result that decode takes immediately never occupies a slot.
   assign w_push      = w_fill && !(w_bypass && out_ready);
   assign w_pop       = w_take && !w_fifo_empty;
   assign w_cnt_next  = r_cnt + {{(CW-1){1'b0}}, w_push} - {{(CW-1){1'b0}}, w_pop};
   assign w_has_room  = (w_cnt_next < CW'(DEPTH));

   assign w_issue_idle = (r_state == S_IDLE) && (w_state_next == S_WAIT);
   assign w_issue_next = w_fill && (w_state_next == S_WAIT);

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         S_IDLE: begin
            if (!redirect && w_has_room) begin
               w_state_next = S_WAIT;
            end
         end
         S_WAIT: begin
            if (w_complete) begin
               w_state_next = (!redirect && w_has_room) ? S_WAIT : S_IDLE;
            end else if (redirect) begin
               w_state_next = S_DROP;
            end
         end
         S_DROP: begin
            if (w_complete) begin
               w_state_next = S_IDLE;
            end
         end
         default: w_state_next = S_IDLE;
      endcase
   end

   always_comb begin
      imem_req  = (r_state != S_IDLE);
      imem_addr = r_addr;
      out_valid = w_out_valid;
      out_inst  = 32'h0;
      out_pc    = 32'h0;
      if (!w_fifo_empty) begin
         out_inst = r_mem_inst[r_rptr];
         out_pc   = r_mem_pc[r_rptr];
      end else if (w_bypass) begin
         out_inst = imem_rdata;
         out_pc   = r_fetch_pc;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_fetch_pc <= RESET_PC & PC_MASK;
         r_addr     <= RESET_PC & PC_MASK;
         r_wptr     <= '0;
         r_rptr     <= '0;
         r_cnt      <= '0;
      end else begin
         if (redirect) begin
            r_fetch_pc <= w_redirect_pc;
         end else if (w_fill) begin
            r_fetch_pc <= r_fetch_pc + 32'd4;
         end

         if (w_issue_idle) begin
            r_addr <= r_fetch_pc;
         end else if (w_issue_next) begin
            r_addr <= r_fetch_pc + 32'd4;
         end

         if (redirect) begin
            r_wptr <= '0;
            r_rptr <= '0;
            r_cnt  <= '0;
         end else begin
            if (w_push) begin
               r_wptr <= r_wptr + AW'(1);
            end
            if (w_pop) begin
               r_rptr <= r_rptr + AW'(1);
            end
            r_cnt <= w_cnt_next;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst && w_push) begin
         r_mem_inst[r_wptr] <= imem_rdata;
         r_mem_pc[r_wptr]   <= r_fetch_pc;
      end
   end

endmodule
